// File: rtl/fetch_ctrl_if.sv
// Fetch path bundle: instruction-memory handshake, redirect/stall inputs, decode-side outputs.
// Latency: none (wires only).
// Backpressure: carried by stall (decode side) and imem_done (memory side).
interface fetch_ctrl_if;
  // Instruction memory side
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_done;
  logic [15:0] imem_data;
  logic        imem_err;
  // Control inputs from execute/decode
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        stall;
  // Decode-facing outputs
  logic        instr_valid;
  logic [15:0] instruction;
  logic [15:0] pc;
  logic [15:0] next_pc;
  logic        halted;
  logic        err;

  // The fetch controller drives requests and decode outputs.
  modport master (
    output imem_req, imem_addr, instr_valid, instruction, pc, next_pc, halted, err,
    input  imem_done, imem_data, imem_err, redirect, redirect_pc, stall
  );

  // Memory plus decode environment around the controller.
  modport slave (
    input  imem_req, imem_addr, instr_valid, instruction, pc, next_pc, halted, err,
    output imem_done, imem_data, imem_err, redirect, redirect_pc, stall
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns PC, fetches into a one-entry buffer, handles redirect/HALT/errors.
// Latency: instr_valid one cycle after imem_done; consume to next request is one cycle.
// Backpressure: stall holds the buffered instruction; outstanding memory requests are never abandoned.
module fetch_ctrl #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [4:0]  HALT_OPCODE = 5'b00000
) (
  input logic         clk,
  input logic         rst,
  fetch_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    ST_START  = 3'd0,
    ST_FETCH  = 3'd1,
    ST_VALID  = 3'd2,
    ST_HALTED = 3'd3,
    ST_ERROR  = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic        pend_vld_q, pend_vld_d;
  logic [15:0] pend_pc_q, pend_pc_d;

  logic [15:0] pc_plus2;
  logic        redir_bad;
  logic        is_halt;

  assign pc_plus2  = pc_q + 16'd2;
  assign redir_bad = bus.redirect && bus.redirect_pc[0];
  assign is_halt   = (instr_q[15:11] == HALT_OPCODE);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_START;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: PC, instruction buffer and pending redirect target.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q       <= RESET_PC;
      instr_q    <= 16'h0000;
      pend_vld_q <= 1'b0;
      pend_pc_q  <= 16'h0000;
    end else begin
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pend_vld_q <= pend_vld_d;
      pend_pc_q  <= pend_pc_d;
    end
  end

  // Next-state and datapath update; errors win over redirects, redirects win over stall/HALT.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    pend_vld_d = pend_vld_q;
    pend_pc_d  = pend_pc_q;

    case (state_q)
      ST_START: begin
        if (redir_bad) begin
          state_d = ST_ERROR;
        end else begin
          if (bus.redirect) pc_d = bus.redirect_pc;
          state_d = ST_FETCH;
        end
      end

      ST_FETCH: begin
        if ((bus.imem_done && bus.imem_err) || redir_bad) begin
          state_d = ST_ERROR;
        end else if (bus.imem_done) begin
          // The request completes here; data is only kept when no redirect is pending.
          if (bus.redirect) begin
            pc_d       = bus.redirect_pc;
            pend_vld_d = 1'b0;
          end else if (pend_vld_q) begin
            pc_d       = pend_pc_q;
            pend_vld_d = 1'b0;
          end else begin
            instr_d = bus.imem_data;
            state_d = ST_VALID;
          end
        end else if (bus.redirect) begin
          // Keep requesting the old address; remember only the newest target.
          pend_vld_d = 1'b1;
          pend_pc_d  = bus.redirect_pc;
        end
      end

      ST_VALID: begin
        if (redir_bad) begin
          state_d = ST_ERROR;
        end else if (bus.redirect) begin
          pc_d    = bus.redirect_pc;
          state_d = ST_FETCH;
        end else if (!bus.stall) begin
          if (is_halt) begin
            state_d = ST_HALTED;
          end else if (pc_q == 16'hFFFE) begin
            state_d = ST_ERROR;
          end else begin
            pc_d    = pc_plus2;
            state_d = ST_FETCH;
          end
        end
      end

      default: begin
        // HALTED and ERROR are terminal until reset.
      end
    endcase
  end

  // Outputs decoded from registered state only.
  always_comb begin
    bus.imem_req    = (state_q == ST_FETCH);
    bus.imem_addr   = pc_q;
    bus.instr_valid = (state_q == ST_VALID);
    bus.instruction = instr_q;
    bus.pc          = pc_q;
    bus.next_pc     = pc_plus2;
    bus.halted      = (state_q == ST_HALTED);
    bus.err         = (state_q == ST_ERROR);
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: handshake timing, stall, redirect, HALT, errors, reset.
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: stall and imem_done are driven per step by hand.
module tb_fetch_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  fetch_ctrl_if bus ();

  fetch_ctrl #(
    .RESET_PC    (16'h0000),
    .HALT_OPCODE (5'b00000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Flags compared as {imem_req, instr_valid, halted, err}.
  task automatic chk_flags(input string tag, input logic [3:0] exp);
    logic [3:0] obs;
    obs = {bus.imem_req, bus.instr_valid, bus.halted, bus.err};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed req/vld/halt/err=%b expected %b", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.imem_done   = 1'b0;
    bus.imem_data   = 16'h0000;
    bus.imem_err    = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 16'h0000;
    bus.stall       = 1'b0;
  endtask

  // Leaves the bench in cycle 1 (first request cycle) after a reset pulse.
  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    #2;
    rst = 1'b1;
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    clear_inputs();
    #3;
    // Asynchronous reset values, before any clock edge.
    chk_flags("rst_flags", 4'b0000);
    chk("rst_instr", bus.instruction, 16'h0000);
    chk("rst_pc", bus.pc, 16'h0000);
    chk("rst_addr", bus.imem_addr, 16'h0000);
    chk("rst_npc", bus.next_pc, 16'h0002);
    rst = 1'b1;
    tick();

    // Zero-wait memory: requests on cycles 1,3,5, valid on 2,4,6.
    for (int i = 0; i < 3; i++) begin
      chk_flags("A_req", 4'b1000);
      chk("A_addr", bus.imem_addr, 16'(2 * i));
      bus.imem_done = 1'b1;
      bus.imem_data = 16'hA000 + 16'(2 * i);
      tick();
      bus.imem_done = 1'b0;
      chk_flags("A_vld", 4'b0100);
      chk("A_instr", bus.instruction, 16'hA000 + 16'(2 * i));
      chk("A_pc", bus.pc, 16'(2 * i));
      tick();
    end

    // HALT at 0x0006, then redirects ignored.
    chk_flags("H_req", 4'b1000);
    chk("H_addr", bus.imem_addr, 16'h0006);
    bus.imem_done = 1'b1;
    bus.imem_data = 16'h0000;
    tick();
    bus.imem_done = 1'b0;
    chk_flags("H_vld", 4'b0100);
    chk("H_pc_vld", bus.pc, 16'h0006);
    tick();
    chk_flags("H_halted", 4'b0010);
    chk("H_pc", bus.pc, 16'h0006);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0200;
    tick();
    bus.redirect = 1'b0;
    chk_flags("H_redir_ign", 4'b0010);
    chk("H_pc_hold", bus.pc, 16'h0006);

    // Latency 3 with a 4-cycle stall on the first instruction.
    do_reset();
    chk_flags("B_req1", 4'b1000);
    tick();
    chk_flags("B_req2", 4'b1000);
    chk("B_addr2", bus.imem_addr, 16'h0000);
    tick();
    chk_flags("B_req3", 4'b1000);
    tick();
    chk_flags("B_req4", 4'b1000);
    chk("B_addr4", bus.imem_addr, 16'h0000);
    bus.imem_done = 1'b1;
    bus.imem_data = 16'h1234;
    bus.stall     = 1'b1;
    tick();
    bus.imem_done = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk_flags("B_stall", 4'b0100);
      chk("B_instr", bus.instruction, 16'h1234);
      chk("B_pc", bus.pc, 16'h0000);
      chk("B_npc", bus.next_pc, 16'h0002);
      tick();
    end
    bus.stall = 1'b0;
    chk_flags("B_drop", 4'b0100);
    tick();
    chk_flags("B_next_req", 4'b1000);
    chk("B_next_addr", bus.imem_addr, 16'h0002);
    bus.imem_done = 1'b1;
    bus.imem_data = 16'h2000;
    tick();
    bus.imem_done = 1'b0;
    chk("B_pc2", bus.pc, 16'h0002);
    tick();

    // Redirect while FETCH of 0x0004 waits; done two cycles later.
    chk("R_addr4", bus.imem_addr, 16'h0004);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0100;
    tick();
    bus.redirect = 1'b0;
    chk_flags("R_hold1", 4'b1000);
    chk("R_old1", bus.imem_addr, 16'h0004);
    tick();
    chk("R_old2", bus.imem_addr, 16'h0004);
    bus.imem_done = 1'b1;
    bus.imem_data = 16'h5555;
    tick();
    bus.imem_done = 1'b0;
    chk_flags("R_discard", 4'b1000);
    chk("R_target", bus.imem_addr, 16'h0100);

    // Redirect and done in the same cycle.
    bus.imem_done   = 1'b1;
    bus.imem_data   = 16'h6666;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0180;
    tick();
    bus.imem_done = 1'b0;
    bus.redirect  = 1'b0;
    chk_flags("S_discard", 4'b1000);
    chk("S_target", bus.imem_addr, 16'h0180);
    bus.imem_done = 1'b1;
    bus.imem_data = 16'h7777;
    tick();
    bus.imem_done = 1'b0;
    chk("S_instr", bus.instruction, 16'h7777);
    chk("S_pc", bus.pc, 16'h0180);
    tick();

    // HALT consume coincident with redirect goes to the target instead.
    chk("T_addr", bus.imem_addr, 16'h0182);
    bus.imem_done = 1'b1;
    bus.imem_data = 16'h0000;
    tick();
    bus.imem_done = 1'b0;
    chk_flags("T_vld", 4'b0100);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0400;
    tick();
    bus.redirect = 1'b0;
    chk_flags("T_not_halted", 4'b1000);
    chk("T_target", bus.imem_addr, 16'h0400);

    // Newer pending redirect overwrites the older one.
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0500;
    tick();
    bus.redirect_pc = 16'h0600;
    chk("P_old1", bus.imem_addr, 16'h0400);
    tick();
    bus.redirect = 1'b0;
    chk("P_old2", bus.imem_addr, 16'h0400);
    bus.imem_done = 1'b1;
    bus.imem_data = 16'h9999;
    tick();
    bus.imem_done = 1'b0;
    chk_flags("P_flags", 4'b1000);
    chk("P_newest", bus.imem_addr, 16'h0600);

    // Error: imem_err with done, sticky against later activity.
    do_reset();
    bus.imem_done = 1'b1;
    bus.imem_err  = 1'b1;
    tick();
    bus.imem_done = 1'b0;
    bus.imem_err  = 1'b0;
    chk_flags("E1_err", 4'b0001);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0010;
    bus.imem_done   = 1'b1;
    tick();
    clear_inputs();
    chk_flags("E1_sticky", 4'b0001);

    // Error: odd redirect target.
    do_reset();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0101;
    tick();
    bus.redirect = 1'b0;
    chk_flags("E2_err", 4'b0001);

    // Error: consume at 0xFFFE (PC wrap).
    do_reset();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'hFFFE;
    tick();
    bus.redirect = 1'b0;
    chk("E3_old", bus.imem_addr, 16'h0000);
    bus.imem_done = 1'b1;
    bus.imem_data = 16'h1111;
    tick();
    chk_flags("E3_req", 4'b1000);
    chk("E3_addr", bus.imem_addr, 16'hFFFE);
    chk("E3_npc_wrap", bus.next_pc, 16'h0000);
    tick();
    bus.imem_done = 1'b0;
    chk_flags("E3_vld", 4'b0100);
    chk("E3_pc", bus.pc, 16'hFFFE);
    tick();
    chk_flags("E3_err", 4'b0001);
    tick();
    chk_flags("E3_sticky", 4'b0001);

    // Reset asserted mid-FETCH at 0x0040.
    do_reset();
    bus.imem_done = 1'b1;
    bus.imem_data = 16'h4321;
    tick();
    bus.imem_done = 1'b0;
    chk("D_instr", bus.instruction, 16'h4321);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0040;
    tick();
    bus.redirect = 1'b0;
    chk_flags("D_req", 4'b1000);
    chk("D_addr", bus.imem_addr, 16'h0040);
    rst = 1'b0;
    #1;
    chk_flags("D_rst_flags", 4'b0000);
    chk("D_rst_instr", bus.instruction, 16'h0000);
    chk("D_rst_pc", bus.pc, 16'h0000);
    chk("D_rst_addr", bus.imem_addr, 16'h0000);
    chk("D_rst_npc", bus.next_pc, 16'h0002);
    rst = 1'b1;
    tick();
    chk_flags("D_first_req", 4'b1000);
    chk("D_first_addr", bus.imem_addr, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
